// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master sequencer: one WRITE/READ/POLL command at a time; with a zero-wait slave, rsp_valid comes 3 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE; AXI valids hold until their handshakes; rsp_valid is a 1-cycle pulse that cannot be stalled.
module axil_cfg_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 16,
  parameter int POLL_GAP = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_data,
  input  logic [DATA_W-1:0]     cmd_mask,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [1:0]            rsp_err,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_BUS = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_POLL_WAIT, S_RSP
  } state_e;

  state_e              state_q, state_d;
  logic                is_poll_q, is_poll_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cmp_q, cmp_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [CNT_W-1:0]    poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]    poll_cnt_inc;
  logic                poll_hit;

  always_comb begin
    state_d      = state_q;
    is_poll_d    = is_poll_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    cmp_d        = cmp_q;
    mask_d       = mask_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    poll_cnt_d   = poll_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    poll_cnt_inc = poll_cnt_q + CNT_W'(1);
    poll_hit     = ((m_rdata ^ cmp_q) & mask_q) == '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          is_poll_d  = (cmd_op == OP_POLL);
          cmp_d      = cmd_data;
          mask_d     = cmd_mask;
          poll_cnt_d = '0;
          case (cmd_op)
            OP_WRITE: begin
              awaddr_d  = cmd_addr;
              wdata_d   = cmd_data;
              aw_pend_d = 1'b1;
              w_pend_d  = 1'b1;
              state_d   = S_WR;
            end
            OP_READ, OP_POLL: begin
              araddr_d = cmd_addr;
              state_d  = S_RD_ADDR;
            end
            default: begin
              rsp_err_d = ERR_ILL;
              state_d   = S_RSP;
            end
          endcase
        end
      end
      // AW and W retire independently; leave once neither is pending
      S_WR: begin
        if (m_awready) aw_pend_d = 1'b0;
        if (m_wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          rsp_err_d = (m_bresp != 2'b00) ? ERR_BUS : ERR_OK;
          state_d   = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (m_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (m_rvalid) begin
          rsp_data_d = m_rdata;
          if (m_rresp != 2'b00) begin
            rsp_err_d = ERR_BUS;
            state_d   = S_RSP;
          end else if (!is_poll_q) begin
            rsp_err_d = ERR_OK;
            state_d   = S_RSP;
          end else begin
            poll_cnt_d = poll_cnt_inc;
            if (poll_hit) begin
              rsp_err_d = ERR_OK;
              state_d   = S_RSP;
            end else if (poll_cnt_inc == CNT_W'(POLL_MAX)) begin
              rsp_err_d = ERR_TMO;
              state_d   = S_RSP;
            end else if (POLL_GAP == 0) begin
              state_d = S_RD_ADDR;
            end else begin
              gap_cnt_d = '0;
              state_d   = S_POLL_WAIT;
            end
          end
        end
      end
      S_POLL_WAIT: begin
        if (int'(gap_cnt_q) >= POLL_GAP - 1) begin
          gap_cnt_d = '0;
          state_d   = S_RD_ADDR;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      is_poll_q  <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      cmp_q      <= '0;
      mask_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 2'b00;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_poll_q  <= is_poll_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      cmp_q      <= cmp_d;
      mask_q     <= mask_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign m_awaddr  = awaddr_q;
  assign m_awvalid = aw_pend_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = '1;
  assign m_wvalid  = w_pend_q;
  assign m_bready  = (state_q == S_WR_RESP);
  assign m_araddr  = araddr_q;
  assign m_arvalid = (state_q == S_RD_ADDR);
  assign m_rready  = (state_q == S_RD_DATA);

endmodule
